axi4_lite_slave_ctrl: RTL

AXI4-Lite slave controller that terminates the five AXI4-Lite channels (AW, W, B, AR, R) and sequences them onto a single-ported register backend, e.g. the AES core's key/data/control register file. Independent write and read state machines share the backend port through a 2-way round-robin arbiter. Responses are generated from the backend's error flag, plus optional protection checking.

---
 rtl/axi4_lite_slave_ctrl_pkg.sv | 30 +++
 rtl/axi4_lite_port_arb.sv | 28 ++
 rtl/axi4_lite_slave_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_slave_ctrl_pkg.sv
// Shared types for the AXI4-Lite slave controller: response codes, FSM states, arbiter flag.
// Defining AXI4_LITE_CTRL_PROT_CHECK_EN makes unprivileged accesses (AxPROT[0]=0) fail with SLVERR.
package axi4_types;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi4_resp_el;

  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_EXEC, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_EXEC, R_DATA} rd_state_t;
  typedef enum logic {LAST_WR = 1'b0, LAST_RD = 1'b1} last_gnt_t;

  // Grant vector bit positions
  localparam int GNT_WR = 0;
  localparam int GNT_RD = 1;

`ifdef AXI4_LITE_CTRL_PROT_CHECK_EN
  localparam bit PROT_CHECK_EN = 1'b1;
`else
  localparam bit PROT_CHECK_EN = 1'b0;
`endif

  function automatic logic prot_reject(input logic [2:0] prot);
    return PROT_CHECK_EN && !prot[0];
  endfunction

endpackage

// File: rtl/axi4_lite_port_arb.sv
// Two-requester round-robin arbiter for the shared register port; bit 0 = write, bit 1 = read.
// On a tie the side not granted last wins; the last-grant flag resets to "write".
module axi4_lite_port_arb
  import axi4_types::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  last_gnt_t last_q;

  always_comb begin
    // NOTE: assign a default before any branch so no path leaves gnt unassigned (which would infer a latch).
    gnt = 2'b00;
    if (req == 2'b11) gnt = (last_q == LAST_RD) ? 2'b01 : 2'b10;
    else              gnt = req;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of block order.
    if (!rst_n)              last_q <= LAST_WR;
    else if (gnt[GNT_RD])    last_q <= LAST_RD;
    else if (gnt[GNT_WR])    last_q <= LAST_WR;
  end

endmodule

// File: rtl/axi4_lite_slave_ctrl.sv
// AXI4-Lite slave: independent write/read FSMs sharing a single-ported register backend.
// Optional AXI4_LITE_CTRL_PROT_CHECK_EN rejects unprivileged accesses like misaligned ones.
module axi4_lite_slave_ctrl
  import axi4_types::*;
#(
  parameter int SIZE_WORD = 32,
  parameter int SIZE_STRB = SIZE_WORD / 8,
  parameter int SIZE_ADDR = SIZE_WORD
) (
  input  logic                 ACLK,
  input  logic                 ARSTn,
  input  logic                 AWVALID,
  output logic                 AWREADY,
  input  logic [SIZE_ADDR-1:0] AWADDR,
  input  logic [2:0]           AWPROT,
  input  logic                 WVALID,
  output logic                 WREADY,
  input  logic [SIZE_WORD-1:0] WDATA,
  input  logic [SIZE_STRB-1:0] WSTRB,
  output logic                 BVALID,
  input  logic                 BREADY,
  output axi4_resp_el          BRESP,
  input  logic                 ARVALID,
  output logic                 ARREADY,
  input  logic [SIZE_ADDR-1:0] ARADDR,
  input  logic [2:0]           ARPROT,
  output logic                 RVALID,
  input  logic                 RREADY,
  output logic [SIZE_WORD-1:0] RDATA,
  output axi4_resp_el          RRESP,
  output logic                 reg_en,
  output logic                 reg_we,
  output logic [SIZE_ADDR-1:0] reg_addr,
  output logic [SIZE_WORD-1:0] reg_wdata,
  output logic [SIZE_STRB-1:0] reg_wstrb,
  input  logic [SIZE_WORD-1:0] reg_rdata,
  input  logic                 reg_err
);

  localparam logic [SIZE_ADDR-1:0] ALIGN_MASK = SIZE_ADDR'(SIZE_STRB - 1);

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  logic                 ready_en, aw_held, w_held, b_err_q, r_err_q;
  logic [SIZE_ADDR-1:0] aw_addr_q, ar_addr_q;
  logic [2:0]           aw_prot_q, ar_prot_q;
  logic [SIZE_WORD-1:0] w_data_q, rdata_q;
  logic [SIZE_STRB-1:0] w_strb_q;
  logic                 aw_hs, w_hs, ar_hs, wr_reject, rd_reject, wr_req, rd_req;
  logic [1:0]           gnt;

  // ready_en keeps all READYs low until the first edge that sees ARSTn high
  assign AWREADY = ready_en && (wr_state == W_IDLE || wr_state == W_WAIT) && !aw_held;
  assign WREADY  = ready_en && (wr_state == W_IDLE || wr_state == W_WAIT) && !w_held;
  assign ARREADY = ready_en && (rd_state == R_IDLE);
  assign aw_hs   = AWVALID && AWREADY;
  assign w_hs    = WVALID && WREADY;
  assign ar_hs   = ARVALID && ARREADY;

  assign wr_reject = (|(aw_addr_q & ALIGN_MASK)) || prot_reject(aw_prot_q);
  assign rd_reject = (|(ar_addr_q & ALIGN_MASK)) || prot_reject(ar_prot_q);
  assign wr_req    = (wr_state == W_EXEC) && !wr_reject;
  assign rd_req    = (rd_state == R_EXEC) && !rd_reject;

  axi4_lite_port_arb u_arb (
    .clk   (ACLK),
    .rst_n (ARSTn),
    .req   ({rd_req, wr_req}),
    .gnt   (gnt)
  );

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      W_IDLE, W_WAIT: begin
        if ((aw_held || aw_hs) && (w_held || w_hs))  wr_next = W_EXEC;
        else if (aw_held || aw_hs || w_held || w_hs) wr_next = W_WAIT;
      end
      W_EXEC:  if (wr_reject || gnt[GNT_WR]) wr_next = W_RESP;
      W_RESP:  if (BREADY) wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      R_IDLE:  if (ar_hs) rd_next = R_EXEC;
      R_EXEC:  if (rd_reject || gnt[GNT_RD]) rd_next = R_DATA;
      R_DATA:  if (RREADY) rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    // NOTE: datapath latches are reset too, so reg_*/RDATA/RESP read as 0/OKAY during reset.
    if (!ARSTn) begin
      ready_en  <= 1'b0;
      wr_state  <= W_IDLE;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      aw_prot_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      b_err_q   <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      wr_state <= wr_next;
      if (aw_hs) begin
        aw_held   <= 1'b1;
        aw_addr_q <= AWADDR;
        aw_prot_q <= AWPROT;
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= WDATA;
        w_strb_q <= WSTRB;
      end
      if (wr_state == W_EXEC) begin
        if (wr_reject)          b_err_q <= 1'b1;
        else if (gnt[GNT_WR])   b_err_q <= reg_err;
      end
      if (wr_state == W_RESP && BREADY) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARSTn) begin
      rd_state  <= R_IDLE;
      ar_addr_q <= '0;
      ar_prot_q <= '0;
      rdata_q   <= '0;
      r_err_q   <= 1'b0;
    end else begin
      rd_state <= rd_next;
      if (ar_hs) begin
        ar_addr_q <= ARADDR;
        ar_prot_q <= ARPROT;
      end
      if (rd_state == R_EXEC) begin
        if (rd_reject) begin
          rdata_q <= '0;
          r_err_q <= 1'b1;
        end else if (gnt[GNT_RD]) begin
          rdata_q <= reg_err ? '0 : reg_rdata;
          r_err_q <= reg_err;
        end
      end
    end
  end

  // Backend port carries only the granted side's word-aligned request
  always_comb begin
    reg_addr  = '0;
    reg_wdata = '0;
    reg_wstrb = '0;
    if (gnt[GNT_WR]) begin
      reg_addr  = aw_addr_q & ~ALIGN_MASK;
      reg_wdata = w_data_q;
      reg_wstrb = w_strb_q;
    end else if (gnt[GNT_RD]) begin
      reg_addr  = ar_addr_q & ~ALIGN_MASK;
    end
  end

  assign reg_en = |gnt;
  assign reg_we = gnt[GNT_WR];

  assign BVALID = (wr_state == W_RESP);
  assign BRESP  = (BVALID && b_err_q) ? SLVERR : OKAY;
  assign RVALID = (rd_state == R_DATA);
  assign RRESP  = r_err_q ? SLVERR : OKAY;
  assign RDATA  = rdata_q;

endmodule
